// File: rtl/issue_stage.sv
// Decode/issue stage: extracts register fields, reads the integer register file with
// writeback bypass, tracks outstanding producers in a scoreboard and registers the issue bundle.
module issue_stage #(
    parameter bit SUPPORT_MULDIV = 1'b1,
    parameter bit SUPPORT_CSR    = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_instr_i,
    input  logic [31:0] fetch_pc_i,
    output logic        fetch_accept_o,
    input  logic        branch_d_request_i,
    input  logic        hold_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_idx_i,
    input  logic [31:0] wb_value_i,
    output logic        opcode_valid_o,
    output logic [31:0] opcode_opcode_o,
    output logic [31:0] opcode_pc_o,
    output logic        opcode_invalid_o,
    output logic [4:0]  opcode_rd_idx_o,
    output logic [4:0]  opcode_ra_idx_o,
    output logic [4:0]  opcode_rb_idx_o,
    output logic [31:0] opcode_ra_operand_o,
    output logic [31:0] opcode_rb_operand_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic        legal_s, rd_used_s, rs1_used_s, rs2_used_s;
    logic [4:0]  rd_idx_s, rs1_idx_s, rs2_idx_s;
    logic [31:0] rs1_val_s, rs2_val_s;
    logic        stall_s, issue_fire_s;

    logic [31:0] rf_q [1:31];
    logic [31:0] rf_d [1:31];
    logic [31:0] pending_q, pending_d;

    logic        valid_q, valid_d;
    logic [31:0] opcode_q, opcode_d;
    logic [31:0] pc_q, pc_d;
    logic        invalid_q, invalid_d;
    logic [4:0]  rd_q, rd_d, ra_q, ra_d, rb_q, rb_d;
    logic [31:0] ra_val_q, ra_val_d, rb_val_q, rb_val_d;

    // Format decode; low opcode bits other than 11 fall through to the illegal default.
    always_comb begin
        legal_s    = 1'b1;
        rd_used_s  = 1'b0;
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        case (fetch_instr_i[6:0])
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                rd_used_s = 1'b1;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                rd_used_s  = 1'b1;
                rs1_used_s = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
            end
            OPC_OP: begin
                rd_used_s  = 1'b1;
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
                if (!SUPPORT_MULDIV && (fetch_instr_i[31:25] == 7'b0000001)) begin
                    legal_s = 1'b0;
                end else begin
                    legal_s = 1'b1;
                end
            end
            OPC_SYSTEM: begin
                rd_used_s  = 1'b1;
                rs1_used_s = 1'b1;
                legal_s    = SUPPORT_CSR;
            end
            default: begin
                legal_s = 1'b0;
            end
        endcase
        rd_idx_s  = (legal_s && rd_used_s)  ? fetch_instr_i[11:7]  : 5'd0;
        rs1_idx_s = (legal_s && rs1_used_s) ? fetch_instr_i[19:15] : 5'd0;
        rs2_idx_s = (legal_s && rs2_used_s) ? fetch_instr_i[24:20] : 5'd0;
    end

    // Operand read with same-cycle writeback bypass.
    always_comb begin
        if (rs1_idx_s == 5'd0) begin
            rs1_val_s = 32'd0;
        end else if (wb_valid_i && (wb_rd_idx_i == rs1_idx_s)) begin
            rs1_val_s = wb_value_i;
        end else begin
            rs1_val_s = rf_q[rs1_idx_s];
        end
        if (rs2_idx_s == 5'd0) begin
            rs2_val_s = 32'd0;
        end else if (wb_valid_i && (wb_rd_idx_i == rs2_idx_s)) begin
            rs2_val_s = wb_value_i;
        end else begin
            rs2_val_s = rf_q[rs2_idx_s];
        end
    end

    // Hazard detection and handshake; a source being written back this cycle is not a hazard.
    always_comb begin
        stall_s = fetch_valid_i &
                  ((pending_q[rs1_idx_s] & ~(wb_valid_i & (wb_rd_idx_i == rs1_idx_s))) |
                   (pending_q[rs2_idx_s] & ~(wb_valid_i & (wb_rd_idx_i == rs2_idx_s))) |
                   pending_q[rd_idx_s]);
        issue_fire_s   = fetch_valid_i & ~hold_i & ~branch_d_request_i & ~stall_s;
        fetch_accept_o = rst_ni & fetch_valid_i & ~hold_i & (branch_d_request_i | ~stall_s);
    end

    // Register file and scoreboard next state; a same-cycle issue re-sets a cleared entry.
    always_comb begin
        rf_d      = rf_q;
        pending_d = pending_q;
        if (wb_valid_i && (wb_rd_idx_i != 5'd0)) begin
            rf_d[wb_rd_idx_i]      = wb_value_i;
            pending_d[wb_rd_idx_i] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (issue_fire_s && (rd_idx_s != 5'd0)) begin
            pending_d[rd_idx_s] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    // Issue register next state; held operands track writebacks to their sources.
    always_comb begin
        valid_d   = valid_q;
        opcode_d  = opcode_q;
        pc_d      = pc_q;
        invalid_d = invalid_q;
        rd_d      = rd_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        ra_val_d  = ra_val_q;
        rb_val_d  = rb_val_q;
        if (hold_i) begin
            if (wb_valid_i && (wb_rd_idx_i != 5'd0) && (wb_rd_idx_i == ra_q)) begin
                ra_val_d = wb_value_i;
            end else begin
                ra_val_d = ra_val_q;
            end
            if (wb_valid_i && (wb_rd_idx_i != 5'd0) && (wb_rd_idx_i == rb_q)) begin
                rb_val_d = wb_value_i;
            end else begin
                rb_val_d = rb_val_q;
            end
        end else if (issue_fire_s) begin
            valid_d   = 1'b1;
            opcode_d  = fetch_instr_i;
            pc_d      = fetch_pc_i;
            invalid_d = ~legal_s;
            rd_d      = rd_idx_s;
            ra_d      = rs1_idx_s;
            rb_d      = rs2_idx_s;
            ra_val_d  = rs1_val_s;
            rb_val_d  = rs2_val_s;
        end else begin
            valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 1; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
            pending_q <= 32'd0;
            valid_q   <= 1'b0;
            opcode_q  <= 32'd0;
            pc_q      <= 32'd0;
            invalid_q <= 1'b0;
            rd_q      <= 5'd0;
            ra_q      <= 5'd0;
            rb_q      <= 5'd0;
            ra_val_q  <= 32'd0;
            rb_val_q  <= 32'd0;
        end else begin
            rf_q      <= rf_d;
            pending_q <= pending_d;
            valid_q   <= valid_d;
            opcode_q  <= opcode_d;
            pc_q      <= pc_d;
            invalid_q <= invalid_d;
            rd_q      <= rd_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            ra_val_q  <= ra_val_d;
            rb_val_q  <= rb_val_d;
        end
    end

    assign opcode_valid_o      = valid_q;
    assign opcode_opcode_o     = opcode_q;
    assign opcode_pc_o         = pc_q;
    assign opcode_invalid_o    = invalid_q;
    assign opcode_rd_idx_o     = rd_q;
    assign opcode_ra_idx_o     = ra_q;
    assign opcode_rb_idx_o     = rb_q;
    assign opcode_ra_operand_o = ra_val_q;
    assign opcode_rb_operand_o = rb_val_q;

endmodule

// File: tb/tb_issue_stage.sv
// Bench for issue_stage: directed scenarios then random traffic against an architectural model
// (register array, pending flags, issue slot) built from the decode/hazard rules.
module tb_issue_stage;

    localparam bit TB_MULDIV = 1'b0;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        fetch_valid, branch_d, hold, wb_valid;
    logic [31:0] fetch_instr, fetch_pc, wb_value;
    logic [4:0]  wb_rd;
    logic        fetch_accept_o, opcode_valid_o, opcode_invalid_o;
    logic [31:0] opcode_opcode_o, opcode_pc_o, opcode_ra_operand_o, opcode_rb_operand_o;
    logic [4:0]  opcode_rd_idx_o, opcode_ra_idx_o, opcode_rb_idx_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    bit          m_pend [32];
    bit          m_valid, m_inv;
    logic [31:0] m_op, m_pc, m_va, m_vb;
    logic [4:0]  m_rd, m_ra, m_rb;

    issue_stage #(.SUPPORT_MULDIV(TB_MULDIV), .SUPPORT_CSR(1'b1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .fetch_valid_i(fetch_valid), .fetch_instr_i(fetch_instr), .fetch_pc_i(fetch_pc),
        .fetch_accept_o(fetch_accept_o), .branch_d_request_i(branch_d), .hold_i(hold),
        .wb_valid_i(wb_valid), .wb_rd_idx_i(wb_rd), .wb_value_i(wb_value),
        .opcode_valid_o(opcode_valid_o), .opcode_opcode_o(opcode_opcode_o),
        .opcode_pc_o(opcode_pc_o), .opcode_invalid_o(opcode_invalid_o),
        .opcode_rd_idx_o(opcode_rd_idx_o), .opcode_ra_idx_o(opcode_ra_idx_o),
        .opcode_rb_idx_o(opcode_rb_idx_o), .opcode_ra_operand_o(opcode_ra_operand_o),
        .opcode_rb_operand_o(opcode_rb_operand_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Which register fields an instruction word uses, straight from the opcode table.
    function automatic void decode(input logic [31:0] w, output bit legal,
                                   output logic [4:0] rd, output logic [4:0] ra,
                                   output logic [4:0] rb);
        bit u_rd, u_ra, u_rb;
        legal = 1'b1; u_rd = 1'b0; u_ra = 1'b0; u_rb = 1'b0;
        case (w[6:0])
            7'h37, 7'h17, 7'h6F: u_rd = 1'b1;
            7'h67, 7'h03, 7'h13: begin u_rd = 1'b1; u_ra = 1'b1; end
            7'h63, 7'h23:        begin u_ra = 1'b1; u_rb = 1'b1; end
            7'h33: begin
                u_rd = 1'b1; u_ra = 1'b1; u_rb = 1'b1;
                if (!TB_MULDIV && w[31:25] == 7'd1) legal = 1'b0;
            end
            7'h73:   begin u_rd = 1'b1; u_ra = 1'b1; end
            default: legal = 1'b0;
        endcase
        rd = (legal && u_rd) ? w[11:7]  : 5'd0;
        ra = (legal && u_ra) ? w[19:15] : 5'd0;
        rb = (legal && u_rb) ? w[24:20] : 5'd0;
    endfunction

    function automatic logic [31:0] rval(input logic [4:0] r, input bit wv,
                                         input logic [4:0] wr, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (wv && wr == r) return wd;
        return m_regs[r];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_pend[i] = 1'b0;
        end
        m_valid = 1'b0; m_inv = 1'b0; m_op = 32'd0; m_pc = 32'd0;
        m_va = 32'd0; m_vb = 32'd0; m_rd = 5'd0; m_ra = 5'd0; m_rb = 5'd0;
    endtask

    // One clock: drive at negedge, check accept mid-cycle, advance model, check issue register.
    task automatic step(input bit fv, input logic [31:0] ins, input logic [31:0] pc,
                        input bit hd, input bit br, input bit wv, input logic [4:0] wr,
                        input logic [31:0] wd, output bit acc);
        bit lg, stall, fire;
        logic [4:0] d_rd, d_ra, d_rb;
        logic [31:0] va, vb;
        fetch_valid = fv; fetch_instr = ins; fetch_pc = pc; hold = hd; branch_d = br;
        wb_valid = wv; wb_rd = wr; wb_value = wd;
        #1;
        decode(ins, lg, d_rd, d_ra, d_rb);
        stall = fv && ((d_ra != 5'd0 && m_pend[d_ra] && !(wv && wr == d_ra)) ||
                       (d_rb != 5'd0 && m_pend[d_rb] && !(wv && wr == d_rb)) ||
                       (d_rd != 5'd0 && m_pend[d_rd]));
        acc  = fv && !hd && (br || !stall);
        fire = fv && !hd && !br && !stall;
        va = rval(d_ra, wv, wr, wd);
        vb = rval(d_rb, wv, wr, wd);
        chk("fetch_accept", {31'd0, fetch_accept_o}, {31'd0, acc});
        @(posedge clk);
        #1;
        if (!hd) begin
            m_valid = fire;
            if (fire) begin
                m_op = ins; m_pc = pc; m_inv = !lg; m_rd = d_rd; m_ra = d_ra; m_rb = d_rb;
                m_va = va; m_vb = vb;
            end
        end else if (wv && wr != 5'd0) begin
            if (wr == m_ra) m_va = wd;
            if (wr == m_rb) m_vb = wd;
        end
        if (wv && wr != 5'd0) begin
            m_regs[wr] = wd;
            m_pend[wr] = 1'b0;
        end
        if (fire && d_rd != 5'd0) m_pend[d_rd] = 1'b1;
        chk("opcode_valid", {31'd0, opcode_valid_o}, {31'd0, m_valid});
        if (m_valid) begin
            chk("opcode_word", opcode_opcode_o, m_op);
            chk("opcode_pc", opcode_pc_o, m_pc);
            chk("opcode_invalid", {31'd0, opcode_invalid_o}, {31'd0, m_inv});
            chk("rd_idx", {27'd0, opcode_rd_idx_o}, {27'd0, m_rd});
            chk("ra_idx", {27'd0, opcode_ra_idx_o}, {27'd0, m_ra});
            chk("rb_idx", {27'd0, opcode_rb_idx_o}, {27'd0, m_rb});
            chk("ra_operand", opcode_ra_operand_o, m_va);
            chk("rb_operand", opcode_rb_operand_o, m_vb);
        end
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        logic [31:0] cur, w;
        logic [6:0] opc_tab [12];
        opc_tab = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                    7'h33, 7'h73, 7'h7F, 7'h32};
        model_reset();
        rst_ni = 1'b0; fetch_valid = 1'b1; fetch_instr = 32'h00700293; fetch_pc = 32'd0;
        hold = 1'b0; branch_d = 1'b0; wb_valid = 1'b0; wb_rd = 5'd0; wb_value = 32'd0;

        // Reset with a valid fetch slot
        #7;
        chk("rst_valid", {31'd0, opcode_valid_o}, 32'd0);
        chk("rst_accept", {31'd0, fetch_accept_o}, 32'd0);
        chk("rst_ra", opcode_ra_operand_o, 32'd0);
        chk("rst_rb", opcode_rb_operand_o, 32'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        // RAW stall on x5 released by same-cycle bypass
        step(1'b1, 32'h00700293, 32'h100, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
        step(1'b1, 32'h00528333, 32'h104, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
        chk("t2_stall", {31'd0, acc}, 32'd0);
        chk("t2_bubble", {31'd0, opcode_valid_o}, 32'd0);
        step(1'b1, 32'h00528333, 32'h104, 1'b0, 1'b0, 1'b1, 5'd5, 32'd7, acc);
        chk("t2_issue", {31'd0, opcode_valid_o}, 32'd1);
        chk("t2_ra", opcode_ra_operand_o, 32'd7);
        chk("t2_rb", opcode_rb_operand_o, 32'd7);

        // Store source written back in the issue cycle
        step(1'b1, 32'h00100193, 32'h108, 1'b0, 1'b0, 1'b1, 5'd6, 32'd14, acc);
        step(1'b1, 32'h00322023, 32'h10C, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234, acc);
        chk("t3_accept", {31'd0, acc}, 32'd1);
        chk("t3_rb", opcode_rb_operand_o, 32'h1234);

        // Redirect discards lui x7 without marking it pending
        step(1'b1, 32'h000013B7, 32'h110, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, acc);
        chk("t4_accept", {31'd0, acc}, 32'd1);
        chk("t4_bubble", {31'd0, opcode_valid_o}, 32'd0);
        step(1'b1, 32'h00038413, 32'h114, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
        chk("t4_x7_free", {31'd0, opcode_valid_o}, 32'd1);

        // Hold for three cycles over an issued beq, with source writebacks
        step(1'b1, 32'h00208463, 32'h118, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
        step(1'b1, 32'h00300493, 32'h11C, 1'b1, 1'b0, 1'b1, 5'd1, 32'h55, acc);
        step(1'b1, 32'h00300493, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, acc);
        step(1'b1, 32'h00300493, 32'h11C, 1'b1, 1'b0, 1'b1, 5'd2, 32'h66, acc);
        chk("t5_pc_held", opcode_pc_o, 32'h118);
        chk("t5_ra_refresh", opcode_ra_operand_o, 32'h55);
        step(1'b1, 32'h00300493, 32'h11C, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
        chk("t5_resume", opcode_pc_o, 32'h11C);

        // Illegal opcode and disabled mul
        step(1'b1, 32'h0000007F, 32'h120, 1'b0, 1'b0, 1'b1, 5'd9, 32'd3, acc);
        chk("t6_inv", {31'd0, opcode_invalid_o}, 32'd1);
        step(1'b1, 32'h02208433, 32'h124, 1'b0, 1'b0, 1'b1, 5'd8, 32'h99, acc);
        chk("t6_mul_inv", {31'd0, opcode_invalid_o}, 32'd1);
        chk("t6_mul_rd", {27'd0, opcode_rd_idx_o}, 32'd0);
        step(1'b1, 32'h008405B3, 32'h128, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
        chk("t6_x8_free", {31'd0, opcode_valid_o}, 32'd1);
        chk("t6_x8_val", opcode_ra_operand_o, 32'h99);

        // Random traffic; an unaccepted instruction stays in the slot
        acc = 1'b1;
        cur = 32'd0;
        for (int n = 0; n < 600; n++) begin
            if (acc) begin
                w = $urandom;
                w[6:0]   = opc_tab[$urandom_range(0, 11)];
                w[11:7]  = 5'($urandom_range(0, 7));
                w[19:15] = 5'($urandom_range(0, 7));
                w[24:20] = 5'($urandom_range(0, 7));
                w[31:25] = ($urandom_range(0, 3) == 0) ? 7'd1 : 7'd0;
                cur = w;
            end
            step($urandom_range(0, 9) < 8, cur, 32'h1000 + 32'(n * 4),
                 $urandom_range(0, 9) < 2, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 9) < 5, 5'($urandom_range(0, 7)), $urandom, acc);
        end

        // Reset in the middle of traffic
        rst_ni = 1'b0;
        fetch_valid = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, opcode_valid_o}, 32'd0);
        chk("mid_rst_accept", {31'd0, fetch_accept_o}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        step(1'b1, 32'h00528333, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, acc);
        chk("post_rst_issue", {31'd0, opcode_valid_o}, 32'd1);
        chk("post_rst_ra", opcode_ra_operand_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
